tron_collision_plotter: RTL and testbench
=========================================

// Module: tron_collision_plotter
// PURPOSE
//  Sits downstream of both tron datapaths and upstream of vga_adapter.
//  Clears the arena, then on each move step checks both heads against a
//  160x120 occupancy bitmap. It marks the visited cells and serialises the
//  two head pixels onto the single VGA plot port. It declares crashes and
//  ends the round. Replaces the ad-hoc board array and plot mux in the top level.
// PARAMETERS
//  X_MAX 160 / Y_MAX 120 - arena size; cell address = y*160 + x
//  BX0 10, BX1 149, BY0 17, BY1 108 - border rectangle (inclusive), pre-marked
//  COLOUR_A 3'b001, COLOUR_B 3'b100, COLOUR_BG 3'b000, COLOUR_WALL 3'b111,
//  COLOUR_CRASH 3'b110 - plot colours
// PORTS
//  clk         in   1  system clock (CLOCK_50 domain); single clock
//  reset       in   1  asynchronous, active-high reset
//  start       in   1  1-cycle pulse: clear arena, begin round
//  step        in   1  1-cycle pulse: heads have advanced, process them
//  ax, bx      in   8  tron A/B head x
//  ay, by      in   7  tron A/B head y
//  vga_x       out  8  pixel x to vga_adapter
//  vga_y       out  7  pixel y to vga_adapter
//  vga_colour  out  3  pixel colour
//  vga_plot    out  1  write strobe, 1 pixel per cycle
//  busy        out  1  high while clearing or processing a step
//  alive       out  1  round in progress, no crash yet
//  crash_a/_b  out  1  sticky per-player crash flags
//  overrun     out  1  sticky: step arrived while busy (step dropped)
// BEHAVIOUR
//  Reset: all outputs 0. FSM goes to IDLE. Bitmap contents are undefined.
//  States: IDLE, CLEAR, READY, RD_A, EV_A, RD_B, EV_B, PL_A, PL_B, DEAD.
//  IDLE: waits for start. step is ignored; overrun is not set.
//  start in any state -> CLEAR next cycle. Clears crash/overrun; alive=0.
//    start beats step in the same cycle.
//  CLEAR: 15-bit counter 0..19199, one cell per cycle.
//    Border cells: bit=1, colour WALL. Others: bit=0, colour BG.
//    vga_plot=1 on every cycle. Takes exactly 19200 cycles.
//    Then READY with alive=1.
//  READY: step sampled at edge N.
//    N+1 RD_A: present addr(A).
//    N+2 EV_A: rdata valid. crash_a if bit=1 or ax>=160 or ay>=120.
//      Otherwise write bit=1 at A.
//    N+3 RD_B / N+4 EV_B: same test for B.
//      If A==B, both crash, regardless of bitmap.
//    N+5 PL_A: plot A, vga_plot=1.
//      Colour A if alive, CRASH if crashed in-bounds, no plot if out of bounds.
//    N+6 PL_B: same rule for B.
//    N+7: READY if no crash, else DEAD with alive=0.
//    busy=1 from N+1 through N+6.
//  ax/ay/bx/by are latched at edge N; later changes do not matter.
//  step while busy or CLEAR: dropped, overrun=1 until next start.
//  DEAD: holds crash flags; step ignored; waits for start.
//  Bitmap has 1-cycle synchronous read latency.
//    Read-during-write to the same address is not relied on.
//  Address arithmetic is 15-bit: (y<<7)+(y<<5)+x.
//    Computed only after the bounds check passes.
// STRUCTURE
//  tron_defs.vh: state encodings, arena and border constants, colour
//  constants, and the addr() function. Shared with the top level and datapaths.
//  Sub-module tron_occupancy_ram: 19200x1, one sync-read port, one write port.
//  Infers M9K memory. Bench can preload and peek it.
//  Remainder: FSM, clear counter, head latches, VGA output registers.
// TESTING
//  1. reset then start: 19200 plots. Cell (10,17) plotted 111, cell (50,50)
//     plotted 000. busy falls after cycle 19200; alive=1.
//  2. A=(25,100), B=(100,100), step: plots (25,100)/001 at N+5 and
//     (100,100)/100 at N+6. No crash; READY at N+7.
//  3. Repeat step with A unchanged: crash_a=1, (25,100) plotted 110,
//     alive=0, state DEAD.
//  4. A=B=(60,60) on a clear cell: crash_a=crash_b=1, alive=0.
//  5. A=(149,50) wall cell -> crash_a. A=(200,50) -> crash_a, no plot in the
//     PL_A slot.
//  6. step at N+3 -> overrun=1, no extra plots. start mid-step -> CLEAR next
//     cycle, flags cleared.

Source files
------------

// File: rtl/tron_collision_plotter_pkg.sv
// Shared arena geometry, plot colours, FSM states and cell-address helpers
// for the tron collision plotter and the datapaths that feed it.
`timescale 1ns/1ps
package tron_collision_plotter_pkg;

  localparam logic [7:0]  X_MAX      = 8'd160;
  localparam logic [6:0]  Y_MAX      = 7'd120;
  localparam int          CELL_COUNT = 19200;
  localparam logic [14:0] LAST_CELL  = 15'd19199;

  localparam logic [7:0]  BX0 = 8'd10;
  localparam logic [7:0]  BX1 = 8'd149;
  localparam logic [6:0]  BY0 = 7'd17;
  localparam logic [6:0]  BY1 = 7'd108;

  localparam logic [2:0]  COLOUR_A     = 3'b001;
  localparam logic [2:0]  COLOUR_B     = 3'b100;
  localparam logic [2:0]  COLOUR_BG    = 3'b000;
  localparam logic [2:0]  COLOUR_WALL  = 3'b111;
  localparam logic [2:0]  COLOUR_CRASH = 3'b110;

  typedef enum logic [3:0] {
    IDLE, CLEAR, READY, RD_A, EV_A, RD_B, EV_B, PL_A, PL_B, DEAD
  } state_t;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
  } head_t;

  // y*160 + x as shifts so no multiplier is inferred
  function automatic logic [14:0] cell_addr(input logic [7:0] x, input logic [6:0] y);
    return 15'({y, 7'd0}) + 15'({y, 5'd0}) + 15'(x);
  endfunction

  function automatic logic in_arena(input logic [7:0] x, input logic [6:0] y);
    return (x < X_MAX) && (y < Y_MAX);
  endfunction

  // outline of the border rectangle only; its interior is open arena
  function automatic logic is_border(input logic [7:0] x, input logic [6:0] y);
    return (((x == BX0) || (x == BX1)) && (y >= BY0) && (y <= BY1)) ||
           (((y == BY0) || (y == BY1)) && (x >= BX0) && (x <= BX1));
  endfunction

endpackage

// File: rtl/tron_collision_plotter_occupancy_ram.sv
// 19200x1 occupancy bitmap: one synchronous read port, one write port.
// No reset so it maps onto block RAM.
`timescale 1ns/1ps
module tron_occupancy_ram
  import tron_collision_plotter_pkg::*;
(
  input  logic        clk,
  input  logic        we,
  input  logic [14:0] waddr,
  input  logic        wdata,
  input  logic [14:0] raddr,
  output logic        rdata
);

  logic mem [0:CELL_COUNT-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/tron_collision_plotter.sv
// Arena clear, per-step collision test of both heads against the occupancy
// bitmap, and serialisation of the head pixels onto the single VGA plot port.
`timescale 1ns/1ps
module tron_collision_plotter
  import tron_collision_plotter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       step,
  input  logic [7:0] ax,
  input  logic [6:0] ay,
  input  logic [7:0] bx,
  input  logic [6:0] by,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic       busy,
  output logic       alive,
  output logic       crash_a,
  output logic       crash_b,
  output logic       overrun
);

  state_t      state_q, state_d;
  head_t       a_q, b_q;
  logic [7:0]  clr_x;
  logic [6:0]  clr_y;
  logic [14:0] clr_addr;

  logic        ram_we, ram_wdata, ram_rdata;
  logic [14:0] ram_waddr, ram_raddr;

  logic        a_in, b_in, same_cell, a_hit, b_hit, clr_wall;
  logic [14:0] a_addr, b_addr;

  assign a_in      = in_arena(a_q.x, a_q.y);
  assign b_in      = in_arena(b_q.x, b_q.y);
  // out-of-arena heads never form an address, so no wrap into a valid cell
  assign a_addr    = a_in ? cell_addr(a_q.x, a_q.y) : '0;
  assign b_addr    = b_in ? cell_addr(b_q.x, b_q.y) : '0;
  assign same_cell = (a_q == b_q);
  assign a_hit     = !a_in || ram_rdata;
  assign b_hit     = !b_in || ram_rdata || same_cell;
  assign clr_wall  = is_border(clr_x, clr_y);

  tron_occupancy_ram u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    busy       = 1'b0;
    vga_x      = '0;
    vga_y      = '0;
    vga_colour = COLOUR_BG;
    vga_plot   = 1'b0;
    ram_we     = 1'b0;
    ram_waddr  = '0;
    ram_wdata  = 1'b0;
    ram_raddr  = '0;
    unique case (state_q)
      IDLE: ;
      CLEAR: begin
        busy       = 1'b1;
        vga_plot   = 1'b1;
        vga_x      = clr_x;
        vga_y      = clr_y;
        vga_colour = clr_wall ? COLOUR_WALL : COLOUR_BG;
        ram_we     = 1'b1;
        ram_waddr  = clr_addr;
        ram_wdata  = clr_wall;
        if (clr_addr == LAST_CELL) state_d = READY;
      end
      READY: if (step) state_d = RD_A;
      RD_A: begin
        busy      = 1'b1;
        ram_raddr = a_addr;
        state_d   = EV_A;
      end
      EV_A: begin
        busy      = 1'b1;
        ram_we    = !a_hit;
        ram_waddr = a_addr;
        ram_wdata = 1'b1;
        state_d   = RD_B;
      end
      // A's mark lands at the end of EV_A, before B's read is sampled
      RD_B: begin
        busy      = 1'b1;
        ram_raddr = b_addr;
        state_d   = EV_B;
      end
      EV_B: begin
        busy      = 1'b1;
        ram_we    = !b_hit;
        ram_waddr = b_addr;
        ram_wdata = 1'b1;
        state_d   = PL_A;
      end
      PL_A: begin
        busy       = 1'b1;
        vga_plot   = a_in;
        vga_x      = a_q.x;
        vga_y      = a_q.y;
        vga_colour = crash_a ? COLOUR_CRASH : COLOUR_A;
        state_d    = PL_B;
      end
      PL_B: begin
        busy       = 1'b1;
        vga_plot   = b_in;
        vga_x      = b_q.x;
        vga_y      = b_q.y;
        vga_colour = crash_b ? COLOUR_CRASH : COLOUR_B;
        state_d    = (crash_a || crash_b) ? DEAD : READY;
      end
      DEAD: ;
      default: state_d = IDLE;
    endcase
    if (start) state_d = CLEAR;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q      <= '0;
      b_q      <= '0;
      clr_x    <= '0;
      clr_y    <= '0;
      clr_addr <= '0;
      alive    <= 1'b0;
      crash_a  <= 1'b0;
      crash_b  <= 1'b0;
      overrun  <= 1'b0;
    end else if (start) begin
      clr_x    <= '0;
      clr_y    <= '0;
      clr_addr <= '0;
      alive    <= 1'b0;
      crash_a  <= 1'b0;
      crash_b  <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (step && busy) overrun <= 1'b1;
      unique case (state_q)
        CLEAR: begin
          if (clr_x == X_MAX - 8'd1) begin
            clr_x <= '0;
            clr_y <= clr_y + 7'd1;
          end else begin
            clr_x <= clr_x + 8'd1;
          end
          clr_addr <= clr_addr + 15'd1;
          if (clr_addr == LAST_CELL) alive <= 1'b1;
        end
        READY: if (step) begin
          a_q <= '{x: ax, y: ay};
          b_q <= '{x: bx, y: by};
        end
        EV_A: if (a_hit) crash_a <= 1'b1;
        // a head-on meeting crashes both regardless of the bitmap
        EV_B: begin
          if (b_hit)     crash_b <= 1'b1;
          if (same_cell) crash_a <= 1'b1;
        end
        PL_B: if (crash_a || crash_b) alive <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tron_collision_plotter.sv
// Directed bench for tron_collision_plotter: arena clear, normal steps,
// self/wall/head-on/out-of-arena crashes, overrun and mid-step restart.
`timescale 1ns/1ps
module tb_tron_collision_plotter;
  import tron_collision_plotter_pkg::*;

  logic       clk = 1'b0;
  logic       reset, start, step;
  logic [7:0] ax, bx;
  logic [6:0] ay, by;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot, busy, alive, crash_a, crash_b, overrun;

  int n_assert = 0;
  int n_fail   = 0;

  logic       s_pl   [1:7];
  logic [7:0] s_x    [1:7];
  logic [6:0] s_y    [1:7];
  logic [2:0] s_c    [1:7];
  logic       s_busy [1:7];
  logic       s_ca   [1:7];
  logic       s_cb   [1:7];
  logic       s_al   [1:7];
  logic       s_ov   [1:7];
  int         s_npl;

  always #5 clk = ~clk;

  tron_collision_plotter dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .step       (step),
    .ax         (ax),
    .ay         (ay),
    .bx         (bx),
    .by         (by),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot),
    .busy       (busy),
    .alive      (alive),
    .crash_a    (crash_a),
    .crash_b    (crash_b),
    .overrun    (overrun)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_plot(input string tag, input int k, input logic [7:0] x,
                            input logic [6:0] y, input logic [2:0] c);
    check({tag, "_plot"}, 32'(s_pl[k]), 32'd1);
    check({tag, "_x"}, 32'(s_x[k]), 32'(x));
    check({tag, "_y"}, 32'(s_y[k]), 32'(y));
    check({tag, "_col"}, 32'(s_c[k]), 32'(c));
  endtask

  // full arena clear; spot-checks wall/background pixels by scan index
  task automatic run_clear();
    int np;
    np = 0;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int i = 0; i < CELL_COUNT; i++) begin
      @(negedge clk);
      if (vga_plot) np++;
      if (i == 0) begin
        check("clr_first_x", 32'(vga_x), 32'd0);
        check("clr_first_y", 32'(vga_y), 32'd0);
        check("clr_busy", 32'(busy), 32'd1);
      end
      if (i == 805) check("clr_5_5_col", 32'(vga_colour), 32'(3'b000));
      if (i == 2730) begin
        check("clr_10_17_x", 32'(vga_x), 32'd10);
        check("clr_10_17_y", 32'(vga_y), 32'd17);
        check("clr_10_17_col", 32'(vga_colour), 32'(3'b111));
      end
      if (i == 8050) begin
        check("clr_50_50_x", 32'(vga_x), 32'd50);
        check("clr_50_50_y", 32'(vga_y), 32'd50);
        check("clr_50_50_col", 32'(vga_colour), 32'(3'b000));
      end
      if (i == 17429) check("clr_149_108_col", 32'(vga_colour), 32'(3'b111));
      if (i == 19199) begin
        check("clr_last_x", 32'(vga_x), 32'd159);
        check("clr_last_y", 32'(vga_y), 32'd119);
        check("clr_last_col", 32'(vga_colour), 32'(3'b000));
      end
    end
    @(negedge clk);
    check("clr_plots", 32'(np), 32'd19200);
    check("clr_done_busy", 32'(busy), 32'd0);
    check("clr_done_alive", 32'(alive), 32'd1);
    check("clr_done_plot", 32'(vga_plot), 32'd0);
    check("clr_done_ca", 32'(crash_a), 32'd0);
    check("clr_done_ov", 32'(overrun), 32'd0);
  endtask

  // step at edge N, then sample cycles N+1..N+7; extra_k/abort_k inject a
  // second step / a start sampled at edge N+k+1 (0 = none)
  task automatic do_step(input logic [7:0] iax, input logic [6:0] iay,
                         input logic [7:0] ibx, input logic [6:0] iby,
                         input int extra_k, input int abort_k);
    @(negedge clk);
    ax = iax; ay = iay; bx = ibx; by = iby; step = 1'b1;
    @(posedge clk); #1;
    step = 1'b0;
    ax = ~iax; ay = ~iay; bx = ~ibx; by = ~iby;
    s_npl = 0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      s_pl[k] = vga_plot;  s_x[k] = vga_x;     s_y[k] = vga_y;
      s_c[k]  = vga_colour; s_busy[k] = busy;  s_ca[k] = crash_a;
      s_cb[k] = crash_b;   s_al[k] = alive;    s_ov[k] = overrun;
      if (vga_plot) s_npl++;
      if (extra_k == k) step = 1'b1;
      if (abort_k == k) start = 1'b1;
      @(posedge clk); #1;
      step = 1'b0; start = 1'b0;
    end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start = 1'b0; step = 1'b0;
    ax = '0; ay = '0; bx = '0; by = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_plot", 32'(vga_plot), 32'd0);
    check("rst_xy", 32'({vga_x, vga_y, vga_colour}), 32'd0);
    check("rst_flags", 32'({busy, alive, crash_a, crash_b, overrun}), 32'd0);
    reset = 1'b0;

    // step in IDLE is ignored and does not flag overrun
    do_step(8'd30, 7'd30, 8'd40, 7'd40, 0, 0);
    check("idle_plots", 32'(s_npl), 32'd0);
    check("idle_busy", 32'(s_busy[1]), 32'd0);
    check("idle_ov", 32'(s_ov[7]), 32'd0);
    check("idle_state", 32'(dut.state_q), 32'(IDLE));

    run_clear();

    // normal move
    do_step(8'd25, 7'd100, 8'd100, 7'd100, 0, 0);
    check("t2_busy1", 32'(s_busy[1]), 32'd1);
    check("t2_busy6", 32'(s_busy[6]), 32'd1);
    check("t2_busy7", 32'(s_busy[7]), 32'd0);
    check("t2_plots", 32'(s_npl), 32'd2);
    check_plot("t2_pla", 5, 8'd25, 7'd100, 3'b001);
    check_plot("t2_plb", 6, 8'd100, 7'd100, 3'b100);
    check("t2_crash", 32'({s_ca[7], s_cb[7]}), 32'd0);
    check("t2_alive", 32'(s_al[7]), 32'd1);
    check("t2_state", 32'(dut.state_q), 32'(READY));

    // A onto its own trail
    do_step(8'd25, 7'd100, 8'd101, 7'd100, 0, 0);
    check("t3_ca_ev", 32'(s_ca[3]), 32'd1);
    check_plot("t3_pla", 5, 8'd25, 7'd100, 3'b110);
    check_plot("t3_plb", 6, 8'd101, 7'd100, 3'b100);
    check("t3_ca", 32'(s_ca[7]), 32'd1);
    check("t3_cb", 32'(s_cb[7]), 32'd0);
    check("t3_alive", 32'(s_al[7]), 32'd0);
    check("t3_state", 32'(dut.state_q), 32'(DEAD));

    // DEAD ignores step
    do_step(8'd30, 7'd30, 8'd40, 7'd40, 0, 0);
    check("dead_plots", 32'(s_npl), 32'd0);
    check("dead_busy", 32'(s_busy[1]), 32'd0);
    check("dead_ov", 32'(s_ov[7]), 32'd0);
    check("dead_ca", 32'(s_ca[7]), 32'd1);

    run_clear();

    // head-on collision, with a second step dropped mid-processing
    do_step(8'd60, 7'd60, 8'd60, 7'd60, 2, 0);
    check("t4_ov", 32'(s_ov[3]), 32'd1);
    check("t4_plots", 32'(s_npl), 32'd2);
    check_plot("t4_pla", 5, 8'd60, 7'd60, 3'b110);
    check_plot("t4_plb", 6, 8'd60, 7'd60, 3'b110);
    check("t4_crash", 32'({s_ca[7], s_cb[7]}), 32'd3);
    check("t4_alive", 32'(s_al[7]), 32'd0);
    check("t4_ov_held", 32'(s_ov[7]), 32'd1);

    run_clear();

    // A into the right wall
    do_step(8'd149, 7'd50, 8'd70, 7'd70, 0, 0);
    check_plot("t5a_pla", 5, 8'd149, 7'd50, 3'b110);
    check_plot("t5a_plb", 6, 8'd70, 7'd70, 3'b100);
    check("t5a_crash", 32'({s_ca[7], s_cb[7]}), 32'd2);
    check("t5a_alive", 32'(s_al[7]), 32'd0);

    run_clear();

    // A off-arena, overrun set, then start in the PL_A slot restarts clear
    do_step(8'd200, 7'd50, 8'd80, 7'd80, 2, 5);
    check("t5b_ca", 32'(s_ca[3]), 32'd1);
    check("t5b_ov", 32'(s_ov[3]), 32'd1);
    check("t5b_pla_none", 32'(s_pl[5]), 32'd0);
    check("t5b_busy5", 32'(s_busy[5]), 32'd1);
    check_plot("t6_clr0", 6, 8'd0, 7'd0, 3'b000);
    check("t6_busy", 32'(s_busy[6]), 32'd1);
    check("t6_flags", 32'({s_ca[6], s_cb[6], s_ov[6], s_al[6]}), 32'd0);
    check("t6_clr1_x", 32'(s_x[7]), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
